ps2_host_port: RTL and testbench

//  PS/2 host-side port that receives device frames and sends host commands over open-drain clk/data.

---
 rtl/ps2_host_port.sv | 245 ++++++++++++++++++++++++
 tb/tb_ps2_host_port.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_port.sv
// PS/2 host port: receives device frames into an RX buffer and sends host commands over open-drain clk/data.
// Build option PS2_RX_FIFO_EN selects a FIFO_DEPTH-entry RX FIFO; otherwise a single holding register.
module ps2_host_port #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int INHIBIT_US  = 100,
    parameter int TIMEOUT_US  = 2000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic [7:0] rx_data,
    output logic       rx_parity_err,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overflow,
    output logic       busy
);

    localparam int CYC_PER_US = CLK_FREQ_HZ / 1_000_000;
    localparam int INH_CYC    = INHIBIT_US * CYC_PER_US;
    localparam int TO_CYC     = TIMEOUT_US * CYC_PER_US;
    localparam int CNT_MAX    = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INH_CYC - 1);
    localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INH_CYC - 2);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_CYC - 1);

    typedef enum logic [2:0] {IDLE, RX, TX_INHIBIT, TX_DATA, TX_ACK} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_cnt;
    logic [8:0]       tx_shift;
    logic [8:0]       rx_shift;
    logic             start_bit;
    logic             push_req;
    logic [8:0]       push_word;
    logic             clk_p0, clk_p1, clk_p2;
    logic             dat_p0, dat_p1;
    logic             clk_fall;
    logic             dat_smp;
    logic             wd_expire;
    logic             pop;
    logic [8:0]       head;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~(^b);
    endfunction

    // Stage p0/p1: two-flop synchroniser; p2 holds the previous synced clock for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_p0 <= 1'b1;
            clk_p1 <= 1'b1;
            clk_p2 <= 1'b1;
            dat_p0 <= 1'b1;
            dat_p1 <= 1'b1;
        end else begin
            clk_p0 <= ps2_clk_i;
            clk_p1 <= clk_p0;
            clk_p2 <= clk_p1;
            dat_p0 <= ps2_dat_i;
            dat_p1 <= dat_p0;
        end
    end

    assign clk_fall  = clk_p2 & ~clk_p1;
    assign dat_smp   = dat_p1;
    assign wd_expire = !clk_fall && (cnt == TO_LAST);
    assign tx_ready  = (state == IDLE) && !clk_fall;
    assign busy      = (state != IDLE);
    assign push_word = {~(^rx_shift), rx_shift[7:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= 4'd0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;
            push_req   <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_err   <= 1'b0;
            push_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (clk_fall) begin
                        state   <= RX;
                        bit_cnt <= 4'd0;
                        cnt     <= '0;
                    end else if (tx_valid) begin
                        state      <= TX_INHIBIT;
                        ps2_clk_oe <= 1'b1;
                        cnt        <= '0;
                    end
                end
                RX: begin
                    if (clk_fall) begin
                        cnt <= '0;
                        if (bit_cnt == 4'd9) begin
                            state    <= IDLE;
                            push_req <= !start_bit && dat_smp;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else if (wd_expire) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        state      <= TX_DATA;
                        cnt        <= '0;
                        bit_cnt    <= 4'd0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == INH_PRE) ps2_dat_oe <= 1'b1;
                    end
                end
                TX_DATA: begin
                    if (clk_fall) begin
                        cnt <= '0;
                        if (bit_cnt == 4'd9) begin
                            ps2_dat_oe <= 1'b0;
                            state      <= TX_ACK;
                        end else begin
                            ps2_dat_oe <= ~tx_shift[0];
                            bit_cnt    <= bit_cnt + 4'd1;
                        end
                    end else if (wd_expire) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_err     <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_ACK: begin
                    if (clk_fall) begin
                        state <= IDLE;
                        if (!dat_smp) tx_done <= 1'b1;
                        else          tx_err  <= 1'b1;
                    end else if (wd_expire) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_err     <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shift registers carry no reset; they are always reloaded before use.
    always_ff @(posedge clk) begin
        if (state == IDLE && !clk_fall && tx_valid)
            tx_shift <= {odd_parity(tx_data), tx_data};
        else if (state == TX_DATA && clk_fall)
            tx_shift <= {1'b0, tx_shift[8:1]};
        if (state == IDLE && clk_fall)
            start_bit <= dat_smp;
        if (state == RX && clk_fall && bit_cnt != 4'd9)
            rx_shift <= {dat_smp, rx_shift[8:1]};
    end

    assign pop = rx_valid && rx_ready;

`ifdef PS2_RX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [8:0]     mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr, rd_ptr;
    logic           full;

    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign rx_valid = (wr_ptr != rd_ptr);
    assign head     = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rx_overflow <= 1'b0;
        end else begin
            rx_overflow <= 1'b0;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_req) begin
                if (!full || pop) wr_ptr      <= wr_ptr + 1'b1;
                else              rx_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_req && (!full || pop)) mem[wr_ptr[PTR_W-1:0]] <= push_word;
    end
`else
    logic hold_vld;

    assign rx_valid = hold_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld    <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            rx_overflow <= 1'b0;
            if (push_req) begin
                if (!hold_vld || pop) hold_vld    <= 1'b1;
                else                  rx_overflow <= 1'b1;
            end else if (pop) begin
                hold_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_req && (!hold_vld || pop)) head <= push_word;
    end
`endif

    assign rx_data       = rx_valid ? head[7:0] : 8'h00;
    assign rx_parity_err = rx_valid & head[8];

endmodule

// File: tb/tb_ps2_host_port.sv
// Scoreboard bench for ps2_host_port with a behavioural PS/2 device on a wired-AND bus.
`timescale 1ns/1ps
module tb_ps2_host_port;

    localparam int H = 10;
`ifdef PS2_RX_FIFO_EN
    localparam int DEPTH = 8;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_i, ps2_dat_i, ps2_clk_oe, ps2_dat_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_err;
    logic [7:0] rx_data;
    logic       rx_parity_err, rx_valid, rx_overflow, busy;
    logic       rx_ready = 1'b1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_fall = 0;
    int ovf_cnt = 0;
    logic [8:0] rx_exp_q[$];
    logic       tx_exp_q[$];

    assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

    ps2_host_port #(
        .CLK_FREQ_HZ(1_000_000),
        .INHIBIT_US (100),
        .TIMEOUT_US (200),
        .FIFO_DEPTH (8)
    ) dut (
        .clk(clk), .rst(rst),
        .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_done(tx_done), .tx_err(tx_err),
        .rx_data(rx_data), .rx_parity_err(rx_parity_err), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .rx_overflow(rx_overflow), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // RX scoreboard: one pop per sampled rx_valid&&rx_ready.
    always @(negedge clk) begin
        if (!rst && rx_valid && rx_ready) begin
            if (rx_exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rx_unexpected actual=%0h required=none", {rx_parity_err, rx_data});
            end else begin
                check("rx_word", {rx_parity_err, rx_data}, rx_exp_q.pop_front());
            end
        end
    end

    // TX scoreboard: 1 = ACK expected, 0 = error expected.
    always @(negedge clk) begin
        logic exp;
        if (!rst && (tx_done || tx_err)) begin
            if (tx_exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tx_unexpected actual=%0b%0b required=none", tx_done, tx_err);
            end else begin
                exp = tx_exp_q.pop_front();
                check("tx_done", tx_done, exp);
                check("tx_err", tx_err, !exp);
            end
        end
    end

    always @(negedge clk) if (rx_overflow) ovf_cnt++;

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                              input logic store, input int abort_bit, input logic chk_lat);
        logic [10:0] bits;
        int n;
        bits = {stop, par, b, 1'b0};
        if (store) rx_exp_q.push_back({~(^{par, b}), b});
        for (int i = 0; i < 11; i++) begin
            if (i == abort_bit) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_rx_valid", rx_valid, 0);
                dev_dat = 1'b1;
                return;
            end
            dev_dat = bits[i];
            repeat (H) @(negedge clk);
            dev_clk = 1'b0;
            if (chk_lat && i == 10) begin
                // two sync stages, fall-detect register, buffer write
                n = 0;
                while (!rx_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check("rx_latency", n, 4);
            end
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
        end
        dev_dat = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    task automatic do_tx(input logic [7:0] b, input logic ack, input int nfalls);
        logic [9:0] s;
        logic [9:0] e;
        int inh, both, n;
        tx_exp_q.push_back(nfalls == 11 && !ack);
        e = {1'b1, ~(^b), b};
        s = '0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        inh = 0;
        both = 0;
        while (ps2_clk_oe && inh < 1000) begin
            inh++;
            if (ps2_dat_oe) both++;
            @(negedge clk);
        end
        check("tx_inhibit_len", inh, 100);
        check("tx_start_len", both, 1);
        check("tx_start_pin", ps2_dat_i, 0);
        for (int k = 1; k <= nfalls; k++) begin
            if (k == 11) dev_dat = ack;
            repeat (H) @(negedge clk);
            dev_clk = 1'b0;
            t_fall = cyc;
            repeat (H) @(negedge clk);
            if (k <= 10) s[k-1] = ps2_dat_i;
            dev_clk = 1'b1;
        end
        dev_dat = 1'b1;
        for (int k = 0; k < 10 && k < nfalls; k++)
            check($sformatf("tx_bit%0d", k), s[k], e[k]);
        if (nfalls < 11) begin
            n = 0;
            while (!tx_err && n < 400) begin
                @(negedge clk);
                n++;
            end
            // two sync stages plus fall-detect register before the 200-cycle watchdog
            check("tx_timeout_delay", cyc - t_fall, 203);
            @(negedge clk);
            check("tx_timeout_clk_oe", ps2_clk_oe, 0);
            check("tx_timeout_dat_oe", ps2_dat_oe, 0);
            check("tx_timeout_busy", busy, 0);
        end
        repeat (30) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", {rx_parity_err, rx_data}, 0);
        check("rst_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
        check("rst_pulses", {tx_done, tx_err, rx_overflow}, 0);

        send_frame(8'hAA, 1'b1, 1'b1, 1'b1, -1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b1, 1'b1, -1, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0, 1'b0, -1, 1'b0);

        do_tx(8'hFF, 1'b0, 11);
        do_tx(8'h3A, 1'b1, 11);
        do_tx(8'h81, 1'b0, 4);

        rx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] v;
            v = 8'h10 + 8'(i);
            send_frame(v, ~(^v), 1'b1, 1'b1, -1, 1'b0);
        end
        check("ovf_before_full", ovf_cnt, 0);
        send_frame(8'h6E, ~(^8'h6E), 1'b1, 1'b0, -1, 1'b0);
        check("ovf_on_extra", ovf_cnt, 1);
        check("ovf_rx_valid_held", rx_valid, 1);
        rx_ready = 1'b1;
        repeat (20) @(negedge clk);

        send_frame(8'hC3, 1'b1, 1'b1, 1'b0, 5, 1'b0);
        repeat (50) @(negedge clk);
        send_frame(8'h55, 1'b1, 1'b1, 1'b1, -1, 1'b0);

        n = 0;
        while ((rx_exp_q.size() != 0 || tx_exp_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rx_queue_drained", rx_exp_q.size(), 0);
        check("tx_queue_drained", tx_exp_q.size(), 0);
        check("final_ovf_total", ovf_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
